// File: rtl/sys_host_cmd.sv
// Host-side UART command master: frames one request, drives the UART TX, and collects the response bytes.
// Optional response watchdog is enabled by defining SYS_HOST_CMD_TIMEOUT_EN.
module sys_host_cmd #(
    parameter int DATA_WIDTH     = 8,
    parameter int RF_ADDR        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ_VLD,
    output logic                    REQ_RDY,
    input  logic [1:0]              REQ_CMD,
    input  logic [RF_ADDR-1:0]      REQ_ADDR,
    input  logic [DATA_WIDTH-1:0]   REQ_DATA,
    input  logic [DATA_WIDTH-1:0]   REQ_OPA,
    input  logic [DATA_WIDTH-1:0]   REQ_OPB,
    input  logic [3:0]              REQ_FUN,
    output logic [DATA_WIDTH-1:0]   UART_TX_DATA,
    output logic                    UART_TX_VLD,
    input  logic                    UART_TX_Busy,
    input  logic [DATA_WIDTH-1:0]   UART_RX_DATA,
    input  logic                    UART_RX_VLD,
    output logic [2*DATA_WIDTH-1:0] RSP_DATA,
    output logic                    RSP_VLD,
    output logic                    RSP_ERR
);

    typedef enum logic [2:0] {
        IDLE, SEND, WAIT_BUSY_HI, WAIT_BUSY_LO, WAIT_RSP, DONE
    } state_t;

    localparam logic [DATA_WIDTH-1:0] HDR_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] HDR_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] HDR_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] HDR_ALU    = DATA_WIDTH'(8'hDD);

    state_t                  state, state_nxt;
    logic [1:0]              idx, idx_nxt;
    logic [1:0]              rx_cnt, rx_cnt_nxt;
    logic [1:0]              last_idx;
    logic [1:0]              rsp_len;
    logic [DATA_WIDTH-1:0]   frame [4];
    logic [DATA_WIDTH-1:0]   tx_data_nxt;
    logic                    tx_vld_nxt;
    logic [2*DATA_WIDTH-1:0] rsp_data_nxt;
    logic                    rsp_vld_nxt;
    logic                    rsp_err_nxt;
    logic                    accept;
    logic                    timeout;
    logic [DATA_WIDTH-1:0]   addr_byte;
    logic [DATA_WIDTH-1:0]   fun_byte;

    assign addr_byte = DATA_WIDTH'(REQ_ADDR);
    assign fun_byte  = DATA_WIDTH'(REQ_FUN);
    // Ready is forced low while reset is held, not just once the state settles.
    assign REQ_RDY   = RST && (state == IDLE);
    assign accept    = REQ_VLD && REQ_RDY;

`ifdef SYS_HOST_CMD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] wd_cnt;
    logic          rsp_enter;
    logic          rx_take;

    assign rsp_enter = (state == WAIT_BUSY_LO) && (state_nxt == WAIT_RSP);
    assign rx_take   = (state == WAIT_RSP) && UART_RX_VLD;
    assign timeout   = (state == WAIT_RSP) && (wd_cnt == TO_LIM);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wd_cnt <= '0;
        end else if (rsp_enter || rx_take) begin
            wd_cnt <= '0;
        end else if ((state == WAIT_RSP) && (wd_cnt != TO_LIM)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            idx          <= '0;
            rx_cnt       <= '0;
            last_idx     <= '0;
            rsp_len      <= '0;
            UART_TX_VLD  <= 1'b0;
            UART_TX_DATA <= '0;
            RSP_DATA     <= '0;
            RSP_VLD      <= 1'b0;
            RSP_ERR      <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            rx_cnt       <= rx_cnt_nxt;
            UART_TX_VLD  <= tx_vld_nxt;
            UART_TX_DATA <= tx_data_nxt;
            RSP_DATA     <= rsp_data_nxt;
            RSP_VLD      <= rsp_vld_nxt;
            RSP_ERR      <= rsp_err_nxt;
            if (accept) begin
                case (REQ_CMD)
                    2'd0:    begin last_idx <= 2'd2; rsp_len <= 2'd0; end
                    2'd1:    begin last_idx <= 2'd1; rsp_len <= 2'd1; end
                    2'd2:    begin last_idx <= 2'd3; rsp_len <= 2'd2; end
                    default: begin last_idx <= 2'd1; rsp_len <= 2'd2; end
                endcase
            end
        end
    end

    // Frame bytes are only read after acceptance, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            case (REQ_CMD)
                2'd0: begin
                    frame[0] <= HDR_WR;
                    frame[1] <= addr_byte;
                    frame[2] <= REQ_DATA;
                    frame[3] <= '0;
                end
                2'd1: begin
                    frame[0] <= HDR_RD;
                    frame[1] <= addr_byte;
                    frame[2] <= '0;
                    frame[3] <= '0;
                end
                2'd2: begin
                    frame[0] <= HDR_ALU_OP;
                    frame[1] <= REQ_OPA;
                    frame[2] <= REQ_OPB;
                    frame[3] <= fun_byte;
                end
                default: begin
                    frame[0] <= HDR_ALU;
                    frame[1] <= fun_byte;
                    frame[2] <= '0;
                    frame[3] <= '0;
                end
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        rx_cnt_nxt   = rx_cnt;
        tx_vld_nxt   = 1'b0;
        tx_data_nxt  = UART_TX_DATA;
        rsp_data_nxt = RSP_DATA;
        rsp_vld_nxt  = 1'b0;
        rsp_err_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt    = SEND;
                    idx_nxt      = 2'd0;
                    rx_cnt_nxt   = 2'd0;
                    rsp_data_nxt = '0;
                end
            end
            SEND: begin
                if (!UART_TX_Busy) begin
                    tx_vld_nxt  = 1'b1;
                    tx_data_nxt = frame[idx];
                    state_nxt   = WAIT_BUSY_HI;
                end
            end
            WAIT_BUSY_HI: begin
                if (UART_TX_Busy) begin
                    state_nxt = WAIT_BUSY_LO;
                end
            end
            WAIT_BUSY_LO: begin
                if (!UART_TX_Busy) begin
                    if (idx != last_idx) begin
                        idx_nxt   = idx + 2'd1;
                        state_nxt = SEND;
                    end else if (rsp_len == 2'd0) begin
                        state_nxt   = DONE;
                        rsp_vld_nxt = 1'b1;
                    end else begin
                        state_nxt = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (UART_RX_VLD) begin
                    if (rx_cnt == 2'd0) begin
                        rsp_data_nxt[DATA_WIDTH-1:0] = UART_RX_DATA;
                    end else begin
                        rsp_data_nxt[2*DATA_WIDTH-1:DATA_WIDTH] = UART_RX_DATA;
                    end
                    rx_cnt_nxt = rx_cnt + 2'd1;
                    if (rx_cnt_nxt == rsp_len) begin
                        state_nxt   = DONE;
                        rsp_vld_nxt = 1'b1;
                    end
                end else if (timeout) begin
                    state_nxt   = DONE;
                    rsp_vld_nxt = 1'b1;
                    rsp_err_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/sys_host_cmd.md
# sys_host_cmd

Host-side command master for the UART register-file/ALU control protocol. Accepts one command request at a time, serializes it into the byte frame the system controller decodes, and drives the UART transmitter. It then collects the response bytes from the UART receiver and returns them as a single response word. It sits at the opposite end of the serial link from the system controller, on the test-host or bridge side.

## Interface
- DATA_WIDTH, 8: UART byte width and RF data width.
- RF_ADDR, 4: register-file address width; the address is zero-extended into one byte.
- TIMEOUT_CYCLES, 65535: response watchdog limit in CLK cycles. Used only when the macro is defined.

- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- REQ_VLD  in  1  command request valid
- REQ_RDY  out  1  block can accept a request
- REQ_CMD  in  2  0=RF write, 1=RF read, 2=ALU with operands, 3=ALU without operands
- REQ_ADDR  in  RF_ADDR  RF address
- REQ_DATA  in  DATA_WIDTH  RF write data
- REQ_OPA, REQ_OPB  in  DATA_WIDTH each  ALU operands
- REQ_FUN  in  4  ALU function
- UART_TX_DATA  out  DATA_WIDTH  byte to transmit
- UART_TX_VLD  out  1  one-cycle transmit strobe
- UART_TX_Busy  in  1  transmitter busy
- UART_RX_DATA  in  DATA_WIDTH  received byte
- UART_RX_VLD  in  1  one-cycle receive strobe, one per byte
- RSP_DATA  out  2*DATA_WIDTH  response word
- RSP_VLD  out  1  one-cycle response strobe
- RSP_ERR  out  1  response timed out; qualified by RSP_VLD

## Operation
- On acceptance (REQ_VLD & REQ_RDY), all request fields are registered. The frame is then fixed:
  - RF write: 0xAA, addr, data.
  - RF read: 0xBB, addr.
  - ALU with operands: 0xCC, OPA, OPB, {4'b0,FUN}.
  - ALU without operands: 0xDD, {4'b0,FUN}.
- Expected response length: write 0 bytes, read 1 byte, either ALU command 2 bytes.
- FSM states: IDLE, SEND, WAIT_BUSY_HI, WAIT_BUSY_LO, WAIT_RSP, DONE.
  - IDLE: REQ_RDY=1. Go to SEND on acceptance, with the byte index at 0.
  - SEND: when UART_TX_Busy=0, drive UART_TX_VLD=1 and UART_TX_DATA=frame[idx] for one cycle, then go to WAIT_BUSY_HI. If Busy=1, hold in SEND with VLD=0.
  - WAIT_BUSY_HI: go to WAIT_BUSY_LO when Busy=1.
  - WAIT_BUSY_LO: when Busy=0, either advance idx and return to SEND, or, after the last byte, go to WAIT_RSP. If zero response bytes are expected, go to DONE instead.
  - WAIT_RSP: each UART_RX_VLD stores a byte. The first byte goes to RSP_DATA[7:0] and the second to RSP_DATA[15:8]. After the final expected byte, go to DONE.
  - DONE: RSP_VLD=1 for one cycle, then go to IDLE.
- RSP_DATA is cleared on acceptance. It holds its value after DONE until the next acceptance. For an RF read, the upper byte is 0. For a write, RSP_DATA is 0.
- UART_RX_VLD outside WAIT_RSP is ignored, and the byte is dropped.
- Reset asserted mid-frame aborts the transaction immediately. Any partially sent frame is not resumed.

## Timing
- Reset values: REQ_RDY=0 while RST=0, then 1 in IDLE. UART_TX_VLD=0, UART_TX_DATA=0, RSP_DATA=0, RSP_VLD=0, RSP_ERR=0. FSM starts in IDLE.
- All outputs are registered, except REQ_RDY, which decodes the state.
- UART_TX_VLD for the first byte is asserted no earlier than the cycle after acceptance.
- RSP_VLD is asserted the cycle after the final UART_RX_VLD. For writes, it is asserted the cycle after Busy falls on the last byte.
- REQ_RDY=0 from the cycle after acceptance through the DONE cycle. The next request can be accepted the cycle after RSP_VLD.
- UART_RX_VLD arriving in the same cycle the FSM enters WAIT_RSP is captured.

## Configuration
- SYS_HOST_CMD_TIMEOUT_EN defined:
  - A counter is cleared on entry to WAIT_RSP and on every UART_RX_VLD, and increments otherwise.
  - When the counter reaches TIMEOUT_CYCLES, go to DONE and pulse RSP_VLD=1 with RSP_ERR=1.
  - RSP_DATA holds whatever bytes were received.
- Not defined: there is no counter, RSP_ERR is tied to 0, and WAIT_RSP waits indefinitely.

## Test plan
- RF write, addr=3, data=0x5A, with a TX model (Busy high for 10 cycles per byte) -> bytes 0xAA, 0x03, 0x5A; then RSP_VLD with RSP_DATA=0x0000 and RSP_ERR=0.
- RF read, addr=2; RX returns 0x3C -> bytes 0xBB, 0x02; RSP_DATA=0x003C one cycle after UART_RX_VLD.
- ALU with operands: OPA=0x12, OPB=0x34, FUN=0 -> bytes 0xCC, 0x12, 0x34, 0x00; RX returns 0x46, 0x00 -> RSP_DATA=0x0046.
- ALU without operands, FUN=2; RX returns 0x08, 0x04 -> bytes 0xDD, 0x02; RSP_DATA=0x0408. A stray RX byte injected during SEND is ignored.
- With the macro defined and TIMEOUT_CYCLES=100: RF read with no RX response -> RSP_VLD with RSP_ERR=1 after 100 cycles. Without the macro, RSP_VLD never rises.
- RST pulsed low during the second byte of an ALU frame -> all outputs return to reset values. A new request issued afterwards sends a complete, correct frame.
